// File: rtl/instruction_fetch_controller.sv
// rtl/instruction_fetch_controller.sv - instruction fetch sequencer with 2-entry decode buffer
//
// Purpose: owns the program counter, drives a synchronous instruction memory,
// captures the returned word one cycle after issue and presents it, tagged
// with its PC, to decode through a valid/ready interface backed by a 2-entry
// FIFO. Handles redirects (epoch-based flush) and level-sensitive halt.
//
// Ports:
//   clock, reset_n       single rising-edge clock, asynchronous active-low reset
//   AddressBus           registered fetch address (word index)
//   InstructionReg       memory data, holds mem[A] the cycle after AddressBus=A
//   redirect_valid/_pc   load new PC and flush
//   halt                 stop issuing new fetches while high
//   instr_valid/_ready   decode handshake; instr_data/instr_pc show the head entry
//   busy                 a fetch is in flight or the buffer is non-empty
//   fetch_count          (FETCH_PERF_COUNTERS_EN) saturating count of pops
//   stall_count          (FETCH_PERF_COUNTERS_EN) saturating count of FETCH cycles without issue
//
// Build option: define FETCH_PERF_COUNTERS_EN to add the performance counters.

module instruction_fetch_controller #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] AddressBus,
  input  logic [DATA_WIDTH-1:0] InstructionReg,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic [31:0]           fetch_count,
  output logic [31:0]           stall_count,
`endif
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } stateT;

  stateT state;
  stateT nextState;

  // pc is the address that follows the candidate currently on AddressBus.
  logic [ADDR_WIDTH-1:0] pc;
  logic                  epoch;

  // Fetch issued last cycle; its data is on InstructionReg this cycle.
  logic                  respValid;
  logic                  respEpoch;
  logic [ADDR_WIDTH-1:0] respPc;

  // Two-entry FIFO, entry 0 is the head.
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] data0, data1;
  logic [ADDR_WIDTH-1:0] pc0, pc1;

  logic       issue;
  logic       popEn;
  logic       pushEn;
  logic [1:0] committed;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = FETCH;
      FETCH:   if (halt) nextState = DRAIN;
      DRAIN: begin
        if (!halt)           nextState = FETCH;
        else if (!respValid) nextState = HALTED;
      end
      HALTED:  if (!halt) nextState = FETCH;
      default: nextState = IDLE;
    endcase
  end

  // Output / control logic
  always_comb begin
    instr_valid = (count != 2'd0);
    instr_data  = data0;
    instr_pc    = pc0;
    popEn       = instr_valid & instr_ready;
    // A redirect discards whatever returns at the same edge.
    pushEn      = respValid & (respEpoch == epoch) & ~redirect_valid;
    // Slots already claimed after this cycle's pop; the departing head frees
    // its slot in time for a new issue, which keeps one word per cycle.
    committed   = count - {1'b0, popEn} + {1'b0, respValid};
    issue       = (state == FETCH) & ~halt & (committed < 2'd2);
    busy        = respValid | (count != 2'd0);
  end

  // PC, address bus and in-flight tracking
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      AddressBus <= RESET_PC;
      pc         <= RESET_PC + ADDR_ONE;
      epoch      <= 1'b0;
      respValid  <= 1'b0;
      respEpoch  <= 1'b0;
      respPc     <= '0;
    end else begin
      respValid <= issue;
      if (issue) begin
        // Tagged with the pre-redirect epoch so a same-cycle redirect drops it.
        respEpoch <= epoch;
        respPc    <= AddressBus;
      end
      if (redirect_valid) begin
        epoch      <= ~epoch;
        AddressBus <= redirect_pc;
        pc         <= redirect_pc + ADDR_ONE;
      end else if (issue) begin
        AddressBus <= pc;
        pc         <= pc + ADDR_ONE;
      end
    end
  end

  // Output buffer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= 2'd0;
      data0 <= '0;
      data1 <= '0;
      pc0   <= '0;
      pc1   <= '0;
    end else if (redirect_valid) begin
      count <= 2'd0;
    end else begin
      case ({pushEn, popEn})
        2'b10: begin
          if (count == 2'd0) begin
            data0 <= InstructionReg;
            pc0   <= respPc;
          end else begin
            data1 <= InstructionReg;
            pc1   <= respPc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          data0 <= data1;
          pc0   <= pc1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            data0 <= InstructionReg;
            pc0   <= respPc;
          end else begin
            data0 <= data1;
            pc0   <= pc1;
            data1 <= InstructionReg;
            pc1   <= respPc;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetchCount;
  logic [31:0] stallCount;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetchCount <= '0;
      stallCount <= '0;
    end else begin
      if (popEn && (fetchCount != '1)) begin
        fetchCount <= fetchCount + 32'd1;
      end
      if ((state == FETCH) && !issue && (stallCount != '1)) begin
        stallCount <= stallCount + 32'd1;
      end
    end
  end

  assign fetch_count = fetchCount;
  assign stall_count = stallCount;
`endif

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// tb/tb_instruction_fetch_controller.sv - self-checking bench for instruction_fetch_controller

module tb_instruction_fetch_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] AddressBus;
  logic [31:0] InstructionReg;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        busy;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int assertCount = 0;
  int failCount   = 0;
  int popsSeen    = 0;

  logic [63:0] expQ[$];
  logic [63:0] monEntry;
  logic        prevHold = 1'b0;
  logic [31:0] prevPc;
  logic [31:0] prevData;

  instruction_fetch_controller #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .AddressBus    (AddressBus),
    .InstructionReg(InstructionReg),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
`ifdef FETCH_PERF_COUNTERS_EN
    .fetch_count   (fetch_count),
    .stall_count   (stall_count),
`endif
    .busy          (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a + 32'hA0;
  endfunction

  // Synchronous instruction memory: mem[A] appears the cycle after AddressBus=A.
  always_ff @(posedge clock) InstructionReg <= memWord(AddressBus);

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic expectRun(input logic [31:0] start, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = start + 32'(i);
      expQ.push_back({a, memWord(a)});
    end
  endtask

  // Drive point: 2 time units after the rising edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_addr"},  64'(AddressBus),  64'(32'h0));
    check({tag, "_valid"}, 64'(instr_valid), 64'(1'b0));
    check({tag, "_data"},  64'(instr_data),  64'(32'h0));
    check({tag, "_pc"},    64'(instr_pc),    64'(32'h0));
    check({tag, "_busy"},  64'(busy),        64'(1'b0));
`ifdef FETCH_PERF_COUNTERS_EN
    check({tag, "_fcnt"},  64'(fetch_count), 64'(32'h0));
    check({tag, "_scnt"},  64'(stall_count), 64'(32'h0));
`endif
  endtask

  // Scoreboard monitor: sampled on the falling edge, a pop happens at the next rising edge.
  always @(negedge clock) begin
    if (reset_n && prevHold) begin
      check("hold_valid", 64'(instr_valid), 64'(1'b1));
      check("hold_pc",    64'(instr_pc),    64'(prevPc));
      check("hold_data",  64'(instr_data),  64'(prevData));
    end
    if (reset_n && instr_valid && instr_ready) begin
      check("pop_expected", 64'(expQ.size() != 0), 64'(1'b1));
      if (expQ.size() != 0) begin
        monEntry = expQ.pop_front();
        check("pop_pc",   64'(instr_pc),   64'(monEntry[63:32]));
        check("pop_data", 64'(instr_data), 64'(monEntry[31:0]));
      end
      popsSeen++;
    end
    prevHold = reset_n && instr_valid && !instr_ready && !redirect_valid;
    prevPc   = instr_pc;
    prevData = instr_data;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int base;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    instr_ready    = 1'b0;
    reset_n        = 1'b0;
    tick();
    tick();
    checkResetValues("reset");

    // Back-pressure from the first word: buffer fills, address freezes at 2.
    expectRun(32'h0, 40);
    reset_n = 1'b1;
    tick();
    check("c1_valid", 64'(instr_valid), 64'(1'b0));
    check("c1_addr",  64'(AddressBus),  64'(32'h0));
    tick();
    check("c2_valid", 64'(instr_valid), 64'(1'b0));
    check("c2_busy",  64'(busy),        64'(1'b1));
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(instr_valid), 64'(1'b1));
      check("stall_pc",    64'(instr_pc),    64'(32'h0));
      check("stall_data",  64'(instr_data),  64'(32'hA0));
      check("stall_addr",  64'(AddressBus),  64'(32'h2));
      tick();
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("stream_valid", 64'(instr_valid), 64'(1'b1));
      tick();
    end

    // Reset pulse that does not line up with the clock.
    reset_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    expQ.delete();
    expectRun(32'h0, 40);
    #15;
    reset_n = 1'b1;
    tick();
    check("r1_valid", 64'(instr_valid), 64'(1'b0));
    tick();
    check("r2_valid", 64'(instr_valid), 64'(1'b0));
    tick();
    check("r3_valid", 64'(instr_valid), 64'(1'b1));
    check("r3_pc",    64'(instr_pc),    64'(32'h0));

    // Redirect while PC 1 returns and PC 2 is issued; neither may appear.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    tick();
    redirect_valid = 1'b0;
    expQ.delete();
    expectRun(32'h10, 40);
    check("redir_addr",  64'(AddressBus),  64'(32'h10));
    check("redir_valid", 64'(instr_valid), 64'(1'b0));
    tick();
    check("redir_valid2", 64'(instr_valid), 64'(1'b0));
    tick();
    check("redir_out_valid", 64'(instr_valid), 64'(1'b1));
    check("redir_out_pc",    64'(instr_pc),    64'(32'h10));
    check("redir_out_data",  64'(instr_data),  64'(32'hB0));
    for (int i = 0; i < 4; i++) tick();

    // Halt during a stream: drain, idle, then resume sequentially.
    halt = 1'b1;
    w = 0;
    while (busy !== 1'b0 && w < 10) begin
      tick();
      w++;
    end
    check("halt_busy",  64'(busy),        64'(1'b0));
    check("halt_valid", 64'(instr_valid), 64'(1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halted_busy", 64'(busy), 64'(1'b0));
      if (expQ.size() != 0) check("halted_addr", 64'(AddressBus), 64'(expQ[0][63:32]));
    end
    halt = 1'b0;
    base = popsSeen;
    w = 0;
    while (popsSeen < base + 4 && w < 20) begin
      tick();
      w++;
    end
    check("resume_pops", 64'(popsSeen >= base + 4), 64'(1'b1));

    // PC wrap at the top of the address space, from a clean reset.
    reset_n = 1'b0;
    expQ.delete();
    #1;
    checkResetValues("wrap_reset");
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    expectRun(32'hFFFF_FFFE, 20);
    reset_n = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("wrap_addr", 64'(AddressBus), 64'(32'hFFFF_FFFE));
    base = popsSeen;
    w = 0;
    while (popsSeen < base + 3 && w < 20) begin
      tick();
      w++;
    end
    check("wrap_pops", 64'(popsSeen >= base + 3), 64'(1'b1));
`ifdef FETCH_PERF_COUNTERS_EN
    check("wrap_fetch_count", 64'(fetch_count), 64'(32'd3));
`endif
    halt = 1'b1;
    w = 0;
    while (busy !== 1'b0 && w < 10) begin
      tick();
      w++;
    end
    check("end_busy", 64'(busy), 64'(1'b0));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
